mult_share_ctrl: RTL and testbench

- Arbitrated controller that shares one multi-cycle shift-add multiplier between two requesters.
- Each requester presents operands over a valid/ready handshake. A round-robin arbiter grants one request at a time.
- The controller sequences the shift-add iterations and returns the product, tagged with the requester ID, over a result valid/ready handshake.
- Sits between the operand sources and the product consumer in the multiplier lab datapath.

---
 rtl/mult_share_ctrl_pkg.sv | 16 +
 rtl/mult_share_ctrl_if.sv | 44 ++++
 rtl/mult_share_ctrl_shift_add_core.sv | 71 +++++++
 rtl/mult_share_ctrl.sv | 119 +++++++++++
 tb/tb_mult_share_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_ctrl_pkg.sv
// Shared widths, FSM encoding and requester IDs for the shared shift-add multiplier.
package mult_pkg;

   localparam int unsigned A_WIDTH_DEF = 8;
   localparam int unsigned B_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam logic ID_REQ0 = 1'b0;
   localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Operand and result handshakes of the shared multiplier; master drives requests, slave is the controller.
interface mult_share_ctrl_if
   import mult_pkg::*;
#(
   parameter int unsigned A_WIDTH = A_WIDTH_DEF,
   parameter int unsigned B_WIDTH = B_WIDTH_DEF,
   parameter int unsigned P_WIDTH = A_WIDTH + B_WIDTH
);

   logic               req0_valid;
   logic [A_WIDTH-1:0] req0_a;
   logic [B_WIDTH-1:0] req0_b;
   logic               req0_ready;
   logic               req1_valid;
   logic [A_WIDTH-1:0] req1_a;
   logic [B_WIDTH-1:0] req1_b;
   logic               req1_ready;
   logic               res_valid;
   logic               res_id;
   logic [P_WIDTH-1:0] res_product;
   logic               res_ready;
   logic               busy;

   modport master (
      output req0_valid, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_a, req1_b,
      input  req1_ready,
      input  res_valid, res_id, res_product,
      output res_ready,
      input  busy
   );

   modport slave (
      input  req0_valid, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_a, req1_b,
      output req1_ready,
      output res_valid, res_id, res_product,
      input  res_ready,
      output busy
   );

endinterface

// File: rtl/mult_share_ctrl_shift_add_core.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, B_WIDTH cycles per product.
module shift_add_core
   import mult_pkg::*;
#(
   parameter int unsigned A_WIDTH = A_WIDTH_DEF,
   parameter int unsigned B_WIDTH = B_WIDTH_DEF,
   parameter int unsigned P_WIDTH = A_WIDTH + B_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [A_WIDTH-1:0] a,
   input  logic [B_WIDTH-1:0] b,
   output logic               done,
   output logic [P_WIDTH-1:0] product
);

   localparam int unsigned CntW = $clog2(B_WIDTH + 1);

   logic [P_WIDTH-1:0] a_sh_q, a_sh_d;
   logic [B_WIDTH-1:0] b_sh_q, b_sh_d;
   logic [P_WIDTH-1:0] acc_q, acc_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               active_q, active_d;

   assign done    = active_q && (cnt_q == CntW'(B_WIDTH - 1));
   assign product = acc_q;

   always_comb begin
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      if (start) begin
         a_sh_d   = P_WIDTH'(a);
         b_sh_d   = b;
         acc_d    = '0;
         cnt_d    = '0;
         active_d = 1'b1;
      end else if (active_q) begin
         if (b_sh_q[0]) begin
            acc_d = acc_q + a_sh_q;
         end
         a_sh_d = a_sh_q << 1;
         b_sh_d = b_sh_q >> 1;
         cnt_d  = cnt_q + CntW'(1);
         // acc stays frozen after the last iteration so the product can be held
         if (done) begin
            active_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter and sequencing FSM sharing one shift-add multiplier between two requesters.
module mult_share_ctrl
   import mult_pkg::*;
#(
   parameter int unsigned A_WIDTH = A_WIDTH_DEF,
   parameter int unsigned B_WIDTH = B_WIDTH_DEF,
   parameter int unsigned P_WIDTH = A_WIDTH + B_WIDTH
) (
   input logic               clk,
   input logic               rst,
   mult_share_ctrl_if.slave  bus
);

   state_e state_q, state_d;
   logic   owner_q, owner_d;
   logic   last_grant_q, last_grant_d;

   logic               req_any;
   logic               grant;
   logic               core_start;
   logic               core_done;
   logic [A_WIDTH-1:0] core_a;
   logic [B_WIDTH-1:0] core_b;
   logic [P_WIDTH-1:0] core_product;

   logic               req0_ready;
   logic               req1_ready;
   logic               res_valid;
   logic               res_id;
   logic [P_WIDTH-1:0] res_product;

   assign req_any = bus.req0_valid || bus.req1_valid;

   // On a tie the requester that was not served last wins.
   always_comb begin
      if (bus.req0_valid && bus.req1_valid) begin
         grant = ~last_grant_q;
      end else if (bus.req1_valid) begin
         grant = ID_REQ1;
      end else begin
         grant = ID_REQ0;
      end
   end

   assign core_a = (grant == ID_REQ1) ? bus.req1_a : bus.req0_a;
   assign core_b = (grant == ID_REQ1) ? bus.req1_b : bus.req0_b;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      core_start   = 1'b0;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      res_valid    = 1'b0;
      res_id       = 1'b0;
      res_product  = '0;
      unique case (state_q)
         StIdle: begin
            if (req_any) begin
               req0_ready   = (grant == ID_REQ0);
               req1_ready   = (grant == ID_REQ1);
               core_start   = 1'b1;
               owner_d      = grant;
               last_grant_d = grant;
               state_d      = StRun;
            end
         end
         StRun: begin
            if (core_done) begin
               state_d = StDone;
            end
         end
         StDone: begin
            res_valid   = 1'b1;
            res_id      = owner_q;
            res_product = core_product;
            if (bus.res_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.req0_ready  = req0_ready;
   assign bus.req1_ready  = req1_ready;
   assign bus.res_valid   = res_valid;
   assign bus.res_id      = res_id;
   assign bus.res_product = res_product;
   assign bus.busy        = (state_q != StIdle);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         owner_q      <= ID_REQ0;
         last_grant_q <= ID_REQ1;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   shift_add_core #(
      .A_WIDTH (A_WIDTH),
      .B_WIDTH (B_WIDTH),
      .P_WIDTH (P_WIDTH)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .start   (core_start),
      .a       (core_a),
      .b       (core_b),
      .done    (core_done),
      .product (core_product)
   );

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: arbitration, latency, backpressure, reset and throughput.
module tb_mult_share_ctrl;
   import mult_pkg::*;

   localparam int unsigned AW = 8;
   localparam int unsigned BW = 4;
   localparam int unsigned PW = 12;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   mult_share_ctrl_if #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) bus ();

   mult_share_ctrl #(
      .A_WIDTH (AW),
      .B_WIDTH (BW),
      .P_WIDTH (PW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input logic id);
      return id ? bus.req1_ready : bus.req0_ready;
   endfunction

   task automatic drive_req(input logic id, input logic v, input logic [AW-1:0] a,
                            input logic [BW-1:0] b);
      if (id) begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
      end else begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
      end
   endtask

   task automatic wait_ready(input logic id, input string tag);
      int k = 0;
      #1;
      while (!rdy(id) && k < 20) begin
         @(negedge clk); #1;
         k++;
      end
      check_eq({tag, "_ready"}, 32'(rdy(id)), 1);
   endtask

   // lat counts negedges with res_valid low after the accept edge; rc counts readies seen meanwhile
   task automatic wait_result(output int lat, output int rc);
      lat = 0;
      rc  = 0;
      forever begin
         @(negedge clk);
         if (bus.req0_ready || bus.req1_ready) rc++;
         if (bus.res_valid || lat >= 30) break;
         lat++;
      end
   endtask

   task automatic run_op(input logic id, input logic [AW-1:0] a, input logic [BW-1:0] b,
                         input logic [PW-1:0] exp, input string tag);
      int lat, rc;
      drive_req(id, 1'b1, a, b);
      wait_ready(id, tag);
      @(posedge clk); #1;
      drive_req(id, 1'b0, '0, '0);
      wait_result(lat, rc);
      check_eq({tag, "_lat"}, 32'(lat), BW);
      check_eq({tag, "_rdy_run"}, 32'(rc), 0);
      check_eq({tag, "_prod"}, 32'(bus.res_product), 32'(exp));
      check_eq({tag, "_id"}, 32'(bus.res_id), 32'(id));
      check_eq({tag, "_busy"}, 32'(bus.busy), 1);
      @(negedge clk);
      check_eq({tag, "_vld_clr"}, 32'(bus.res_valid), 0);
      check_eq({tag, "_idle"}, 32'(bus.busy), 0);
   endtask

   initial begin
      int lat, rc, rv;
      int acc_cyc [3];
      logic [AW-1:0] b2b_a [3];
      logic [BW-1:0] b2b_b [3];
      logic [PW-1:0] b2b_p [3];

      rst = 1'b1;
      bus.res_ready = 1'b1;
      drive_req(1'b0, 1'b0, '0, '0);
      drive_req(1'b1, 1'b0, '0, '0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_busy", 32'(bus.busy), 0);
      check_eq("rst_res_valid", 32'(bus.res_valid), 0);
      check_eq("rst_res_id", 32'(bus.res_id), 0);
      check_eq("rst_res_product", 32'(bus.res_product), 0);
      check_eq("rst_req0_ready", 32'(bus.req0_ready), 0);
      check_eq("rst_req1_ready", 32'(bus.req1_ready), 0);
      rst = 1'b0;

      // Tie after reset: req0 first, then req1
      drive_req(1'b0, 1'b1, 8'd7, 4'd3);
      drive_req(1'b1, 1'b1, 8'd9, 4'd5);
      #1;
      check_eq("tie_r0_ready", 32'(bus.req0_ready), 1);
      check_eq("tie_r1_ready", 32'(bus.req1_ready), 0);
      @(posedge clk); #1;
      drive_req(1'b0, 1'b0, '0, '0);
      wait_result(lat, rc);
      check_eq("tie0_lat", 32'(lat), BW);
      check_eq("tie0_prod", 32'(bus.res_product), 21);
      check_eq("tie0_id", 32'(bus.res_id), 0);
      @(negedge clk);
      check_eq("tie1_ready", 32'(bus.req1_ready), 1);
      @(posedge clk); #1;
      drive_req(1'b1, 1'b0, '0, '0);
      wait_result(lat, rc);
      check_eq("tie1_lat", 32'(lat), BW);
      check_eq("tie1_prod", 32'(bus.res_product), 45);
      check_eq("tie1_id", 32'(bus.res_id), 1);
      @(negedge clk);
      check_eq("tie1_idle", 32'(bus.busy), 0);
      // Second tie goes back to req0; both drop before the edge so nothing is recorded
      drive_req(1'b0, 1'b1, 8'd7, 4'd3);
      drive_req(1'b1, 1'b1, 8'd9, 4'd5);
      #1;
      check_eq("tie2_r0_ready", 32'(bus.req0_ready), 1);
      check_eq("tie2_r1_ready", 32'(bus.req1_ready), 0);
      drive_req(1'b0, 1'b0, '0, '0);
      drive_req(1'b1, 1'b0, '0, '0);
      @(negedge clk);
      check_eq("drop_not_recorded", 32'(bus.busy), 0);

      run_op(1'b0, 8'd13, 4'd11, 12'd143, "single");
      run_op(1'b0, 8'd255, 4'd15, 12'd3825, "max");
      run_op(1'b1, 8'd0, 4'd9, 12'd0, "zero_a");
      run_op(1'b0, 8'd1, 4'd0, 12'd0, "zero_b");

      // Backpressure: hold result 10 cycles while req1 waits
      bus.res_ready = 1'b0;
      drive_req(1'b0, 1'b1, 8'd6, 4'd7);
      wait_ready(1'b0, "bp");
      @(posedge clk); #1;
      drive_req(1'b0, 1'b0, '0, '0);
      drive_req(1'b1, 1'b1, 8'd3, 4'd3);
      wait_result(lat, rc);
      check_eq("bp_lat", 32'(lat), BW);
      for (int i = 0; i < 10; i++) begin
         check_eq("bp_hold_valid", 32'(bus.res_valid), 1);
         check_eq("bp_hold_prod", 32'(bus.res_product), 42);
         check_eq("bp_hold_id", 32'(bus.res_id), 0);
         check_eq("bp_hold_r1_ready", 32'(bus.req1_ready), 0);
         @(negedge clk);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_released", 32'(bus.res_valid), 0);
      wait_ready(1'b1, "bp_r1");
      @(posedge clk); #1;
      drive_req(1'b1, 1'b0, '0, '0);
      wait_result(lat, rc);
      check_eq("bp_r1_prod", 32'(bus.res_product), 9);
      check_eq("bp_r1_id", 32'(bus.res_id), 1);
      @(negedge clk);
      check_eq("bp_r1_idle", 32'(bus.busy), 0);

      // Reset during the second RUN cycle discards the operation
      drive_req(1'b0, 1'b1, 8'd5, 4'd5);
      wait_ready(1'b0, "mid_rst");
      @(posedge clk); #1;
      drive_req(1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_busy", 32'(bus.busy), 0);
      check_eq("mid_rst_valid", 32'(bus.res_valid), 0);
      rv = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.res_valid) rv++;
      end
      check_eq("mid_rst_no_result", 32'(rv), 0);
      run_op(1'b1, 8'd2, 4'd2, 12'd4, "post_rst");

      // Back-to-back from req1 with valid held throughout
      b2b_a[0] = 8'd10;  b2b_b[0] = 4'd10; b2b_p[0] = 12'd100;
      b2b_a[1] = 8'd200; b2b_b[1] = 4'd12; b2b_p[1] = 12'd2400;
      b2b_a[2] = 8'd17;  b2b_b[2] = 4'd15; b2b_p[2] = 12'd255;
      drive_req(1'b1, 1'b1, b2b_a[0], b2b_b[0]);
      for (int i = 0; i < 3; i++) begin
         wait_ready(1'b1, "b2b");
         acc_cyc[i] = cyc;
         @(posedge clk); #1;
         if (i < 2) drive_req(1'b1, 1'b1, b2b_a[i+1], b2b_b[i+1]);
         else drive_req(1'b1, 1'b0, '0, '0);
         wait_result(lat, rc);
         check_eq("b2b_lat", 32'(lat), BW);
         check_eq("b2b_rdy_run", 32'(rc), 0);
         check_eq("b2b_prod", 32'(bus.res_product), 32'(b2b_p[i]));
         check_eq("b2b_id", 32'(bus.res_id), 1);
      end
      check_eq("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), BW + 2);
      check_eq("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), BW + 2);
      @(negedge clk);
      check_eq("b2b_idle", 32'(bus.busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
